// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: frame constants, FSM state type and the
// parity helper. Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } uart_rx_state_e;
`endif

  // Even parity: the data bits plus the parity bit must XOR to zero.
  function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ~(^d ^ p);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is a
// parameter so idle-high lines come out of reset already at their idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two register stages; only r_sync is safe to use downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver, 8 data bits, LSB first, one stop bit.
// Optional feature macro: UART_RX_PARITY_EN (adds an even parity bit, the
// PARITY state and the parity_err output).
// Output semantics: valid, frame_err and parity_err are single-cycle pulses,
// at most one per frame and never together; data only changes with valid.
// dbg_state exposes the FSM state for observation.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic [7:0]           data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy,
  output uart_rx_state_e       dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(DATA_BITS - 1);

  logic                 w_din_s;
  logic                 w_tick;
  uart_rx_state_e       r_state;
  uart_rx_state_e       w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic [7:0]           r_shift;
  logic [7:0]           r_data;
  logic                 r_armed;
  logic                 r_valid;
  logic                 r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_parity_err;
  logic                 r_par_bad;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_din (
    .clk (clk),
    .rst (rst),
    .i_d (din),
    .o_q (w_din_s)
  );

  // Sample tick: mid start bit in START, end of the bit period elsewhere.
  assign w_tick = (r_state == START) ? (r_cnt == CNT_HALF) : (r_cnt == CNT_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (r_armed && !w_din_s) w_state_next = START;
      START: if (w_tick) w_state_next = w_din_s ? IDLE : DATA;
      DATA: begin
        if (w_tick && (r_bit_idx == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (w_tick) w_state_next = STOP;
`endif
      STOP:    if (w_tick) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Bit-period counter: held at zero in IDLE, restarts after every sample.
  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE) || w_tick) r_cnt <= '0;
    else                                     r_cnt <= r_cnt + 1'b1;
  end

  // Datapath: arming, shifting, parity capture and result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_bit_idx   <= '0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
      r_par_bad    <= 1'b0;
`endif
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
          r_par_bad <= 1'b0;
`endif
          // A start edge only counts after the line was seen idle high.
          if (w_state_next != IDLE) r_armed <= 1'b0;
          else if (w_din_s)         r_armed <= 1'b1;
        end
        DATA: begin
          if (w_tick) begin
            r_shift   <= {w_din_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick) r_par_bad <= ~even_parity_ok(r_shift, w_din_s);
        end
`endif
        STOP: begin
          if (w_tick) begin
            // A good stop bit doubles as the idle-high that re-arms the
            // receiver, so a start bit right after it is caught.
            r_armed <= w_din_s;
            if (!w_din_s) begin
              r_frame_err <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (r_par_bad) begin
              r_parity_err <= 1'b1;
            end
`endif
            else begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end
          end
        end
        default: r_armed <= 1'b0;
      endcase
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign frame_err  = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;

endmodule
